// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind the PE array: sums each output neuron over several
// kernel passes in a local buffer, then drains results (optional ReLU) on a valid/ready stream.
module psum_accumulator #(
  parameter int W = 16,
  parameter int A = 5,
  parameter int P = 8
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                start,
  input  logic [A-1:0]        cfg_len_m1,
  input  logic [P-1:0]        cfg_passes_m1,
  input  logic                cfg_relu,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} stateT;

  stateT               state, stateNext;
  logic [A-1:0]        addr, addrNext;
  logic [P-1:0]        pass, passNext;
  logic [A-1:0]        lenM1;
  logic [P-1:0]        passesM1;
  logic                reluEn;
  logic                beat;
  logic                loadOut;
  logic                finish;
  logic signed [W-1:0] psumBuf [2**A];

  function automatic logic signed [W-1:0] wrapAdd(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    return a + b;
  endfunction

  function automatic logic signed [W-1:0] applyRelu(input logic signed [W-1:0] v,
                                                    input logic en);
    return (en && v[W-1]) ? '0 : v;
  endfunction

  assign beat = in_valid && in_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    addrNext  = addr;
    passNext  = pass;
    in_ready  = 1'b0;
    loadOut   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = ACCUM;
          addrNext  = '0;
          passNext  = '0;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (beat) begin
          if (addr == lenM1) begin
            addrNext = '0;
            if (pass == passesM1) begin
              stateNext = DRAIN;
            end else begin
              passNext = pass + 1'b1;
            end
          end else begin
            addrNext = addr + 1'b1;
          end
        end
      end
      DRAIN: begin
        // addr points at the next neuron to load into the output slot
        if (out_valid && out_ready && out_last) begin
          stateNext = IDLE;
          finish    = 1'b1;
        end else if (!out_valid || out_ready) begin
          loadOut  = 1'b1;
          addrNext = addr + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      addr     <= '0;
      pass     <= '0;
      lenM1    <= '0;
      passesM1 <= '0;
      reluEn   <= 1'b0;
    end else begin
      addr <= addrNext;
      pass <= passNext;
      if (state == IDLE && start) begin
        lenM1    <= cfg_len_m1;
        passesM1 <= cfg_passes_m1;
        reluEn   <= cfg_relu;
      end
    end
  end

  // Accumulate stage: pass 0 captures, later passes add with two's-complement wrap
  always_ff @(posedge CLK) begin
    if (beat) begin
      psumBuf[addr] <= (pass == '0) ? in_data : wrapAdd(psumBuf[addr], in_data);
    end
  end

  // Drain stage: registered output slot
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (loadOut) begin
        out_valid <= 1'b1;
        out_data  <= applyRelu(psumBuf[addr], reluEn);
        out_last  <= (addr == lenM1);
      end
    end
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the PE array.
- Consumes the column partial-sum stream (the W-bit adderOut of the last PE in a column) over multiple kernel passes.
- Accumulates each output neuron's partial sums in a local register buffer, then drains the finished neurons, with optional ReLU, over a valid/ready stream to the output neuron store.

Parameters:
- W, 16, datapath width of partial sums and results (two's complement)
- A, 5, buffer address width; buffer holds 2^A output neurons
- P, 8, width of the pass-count configuration field

Ports:
- CLK  input  1  clock, rising edge
- RESETn  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches cfg_* and begins a job (IDLE only)
- cfg_len_m1  input  A  neurons per pass minus 1
- cfg_passes_m1  input  P  number of accumulation passes minus 1
- cfg_relu  input  1  apply ReLU on drain
- in_valid  input  1  partial-sum beat valid
- in_ready  output  1  block accepts beat
- in_data  input  W  partial sum from PE column
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- out_data  output  W  accumulated (optionally ReLU'd) neuron value
- out_last  output  1  marks final result of job
- busy  output  1  high in ACCUM or DRAIN
- done  output  1  one-cycle pulse after last result handshake

Behaviour:
- One clock CLK. Reset RESETn is asynchronous, active-low.
- Reset values:
  - state = IDLE; all counters 0.
  - in_ready, out_valid, out_last, busy, done = 0; out_data = 0.
  - Buffer contents are not reset; the first pass overwrites them.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - in_ready = 0.
  - start = 1: latch cfg_len_m1, cfg_passes_m1 and cfg_relu into internal registers; clear addr and pass; go to ACCUM next cycle.
  - start in any other state is ignored.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready.
  - On a beat at pass 0: buf[addr] <= in_data.
  - On a beat at a later pass: buf[addr] <= buf[addr] + in_data, wrapping mod 2^W with no saturation.
  - Address advance on a beat:
    - addr != len_m1: addr increments.
    - addr == len_m1: addr wraps to 0 and pass increments.
    - addr == len_m1 and pass == passes_m1: go to DRAIN, with addr = 0.
  - No beat: all state holds.
- DRAIN:
  - in_ready = 0.
  - out_data is registered, loaded from buf[addr] when the slot is empty or a handshake completes.
  - ReLU: if relu set and bit W-1 of the value is 1, output 0; otherwise output the value unchanged.
  - out_valid rises one cycle after entering DRAIN.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_last = 1 exactly on the beat for addr == len_m1.
  - Handshake on out_valid && out_ready:
    - Not last: next value presented the following cycle, so back-to-back throughput is 1 per cycle.
    - Last: out_valid drops, done pulses for one cycle, state goes to IDLE.
- busy = (state != IDLE).
- Boundaries:
  - cfg_len_m1 = 0: single neuron; wrap and pass increment occur on every beat.
  - cfg_passes_m1 = 0: single pass, pure capture with no addition.
  - Maximum configuration (len_m1 = 2^A-1, passes_m1 = 2^P-1) must be supported.
- Latency: the first result is presented 2 cycles after the final accepted input beat (1 cycle to enter DRAIN, 1 cycle to register out_data).
- Reset asserted mid-job: immediate return to IDLE with all outputs at their reset values. A partially drained job is lost; no done pulse.

Test Plan:
- Single pass, len_m1 = 3, relu = 0, inputs 5, -2, 7, 0; out_ready = 1 -> outputs 5, 0xFFFE, 7, 0; out_last on 4th beat; done one cycle after it.
- len_m1 = 1, passes_m1 = 2, inputs (10, 20), (1, -30), (4, 5) -> outputs 15, -5 (0xFFFB); with relu = 1 -> outputs 15, 0.
- Overflow: len_m1 = 0, passes_m1 = 1, inputs 0x7FFF then 0x0002 -> output 0x8001 (wraps); with relu = 1 -> output 0.
- Backpressure: len_m1 = 2, out_ready toggling 0,0,1,0,1,1 -> each value held stable while stalled; exactly 3 handshakes; in_ready = 0 throughout DRAIN; start during DRAIN ignored.
- Sparse input: in_valid asserted every third cycle for len_m1 = 3, passes_m1 = 1 -> results identical to the dense case; addr and pass do not advance on idle cycles.
- Reset: RESETn pulled low mid-ACCUM (pass 1, addr 2) -> next cycle busy = 0, in_ready = 0, out_valid = 0; a new start with a fresh config completes correctly.
